// File: rtl/uart_pkg.sv
// uart_pkg: shared UART TX types: FSM state encoding, latched frame config and length clamp.
package uart_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_START  = 3'd1;
    localparam state_t S_DATA   = 3'd2;
    localparam state_t S_PARITY = 3'd3;
    localparam state_t S_STOP   = 3'd4;

    typedef struct packed {
        logic [3:0]  len;
        logic        parity_en;
        logic        odd;
        logic        stop2;
        logic [31:0] baud_div;
    } cfg_t;

    function automatic logic [3:0] eff_len(input logic [3:0] len, input int unsigned max_len);
        return (len == 4'd0 || 32'(len) > max_len) ? 4'(max_len) : len;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous show-ahead FIFO with full/empty flags; only used when UART_TX_FIFO_EN is defined.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wp, rp;

    // Extra pointer bit tells full from empty when the indices match.
    assign empty = wp == rp;
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign dout  = mem[rp[AW-1:0]];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full) wp <= wp + ONE;
            if (pop && !empty) rp <= rp + ONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (push && !full) mem[wp[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: UART transmitter with baud divider, valid/ready input and runtime frame format.
// Define UART_TX_FIFO_EN to put a FIFO_DEPTH-entry FIFO in front of the engine.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int BAUD_DIV_WIDTH = 16,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic [BAUD_DIV_WIDTH-1:0] iBAUD_DIV,
    input  logic [3:0]                iDATA_LEN,
    input  logic                      iPARITY_EN,
    input  logic                      iODD_PARITY,
    input  logic                      iSTOP_BIT,
    input  logic                      iVALID,
    input  logic [DATA_WIDTH-1:0]     iDATA,
    output logic                      oREADY,
    output logic                      oBUSY,
    output logic                      oTX_DONE,
    output logic                      oUART_TX
);

    if (DATA_WIDTH < 5 || DATA_WIDTH > 9 || BAUD_DIV_WIDTH > 32 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
        $error("uart_tx_engine: illegal DATA_WIDTH, BAUD_DIV_WIDTH or FIFO_DEPTH");
    end

    state_t                st;
    cfg_t                  cfg_in, cfg_q;
    logic [31:0]           cnt;
    logic [3:0]            bit_cnt;
    logic [DATA_WIDTH-1:0] shreg, word;
    logic                  par_in, par_q, tx_q;
    logic                  avail, take, tick, last_stop, last_data, line_nxt;

    assign cfg_in = '{len:       eff_len(iDATA_LEN, DATA_WIDTH),
                      parity_en: iPARITY_EN,
                      odd:       iODD_PARITY,
                      stop2:     iSTOP_BIT,
                      baud_div:  32'(iBAUD_DIV)};

`ifdef UART_TX_FIFO_EN
    logic fifo_full, fifo_empty;

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_WIDTH)) u_fifo (
        .CLK   (CLK),
        .RST_N (RST_N),
        .push  (iVALID),
        .din   (iDATA),
        .pop   (take),
        .dout  (word),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign oREADY = !fifo_full;
    assign avail  = !fifo_empty;
`else
    assign oREADY = st == S_IDLE;
    assign avail  = iVALID;
    assign word   = iDATA;
`endif

    assign take      = (st == S_IDLE) && avail;
    assign tick      = cnt == 32'd0;
    assign last_stop = !cfg_q.stop2 || bit_cnt[0];
    assign last_data = bit_cnt == cfg_q.len - 4'd1;
    assign oTX_DONE  = (st == S_STOP) && tick && last_stop;
    assign oBUSY     = st != S_IDLE;
    assign oUART_TX  = tx_q;

    // Parity covers only the bits actually sent.
    always_comb begin
        par_in = cfg_in.odd;
        for (int i = 0; i < DATA_WIDTH; i++) par_in = par_in ^ (word[i] & (i < int'(cfg_in.len)));
    end

    // Line lags the state by one register stage.
    assign line_nxt = (st == S_START)  ? 1'b0     :
                      (st == S_DATA)   ? shreg[0] :
                      (st == S_PARITY) ? par_q    : 1'b1;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            st      <= S_IDLE;
            cfg_q   <= '0;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            tx_q <= line_nxt;
            cnt  <= (st == S_IDLE) ? cfg_in.baud_div : tick ? cfg_q.baud_div : cnt - 32'd1;
            if (take) begin
                shreg   <= word;
                cfg_q   <= cfg_in;
                par_q   <= par_in;
                bit_cnt <= '0;
                st      <= S_START;
            end else if (tick) begin
                case (st)
                    S_START:  st <= S_DATA;
                    S_DATA: begin
                        shreg   <= shreg >> 1;
                        bit_cnt <= last_data ? 4'd0 : bit_cnt + 4'd1;
                        if (last_data) st <= cfg_q.parity_en ? S_PARITY : S_STOP;
                    end
                    S_PARITY: st <= S_STOP;
                    S_STOP: begin
                        bit_cnt <= bit_cnt + 4'd1;
                        if (last_stop) st <= S_IDLE;
                    end
                    default:  st <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: table-driven frame checks plus hand-written handshake, FIFO and reset sequences.
module tb_uart_tx_engine;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [15:0] iBAUD_DIV = 16'd3;
    logic [3:0]  iDATA_LEN = 4'd8;
    logic        iPARITY_EN = 1'b0;
    logic        iODD_PARITY = 1'b0;
    logic        iSTOP_BIT = 1'b0;
    logic        iVALID = 1'b0;
    logic [7:0]  iDATA = 8'h00;
    logic        oREADY, oBUSY, oTX_DONE, oUART_TX;

    int n_chk = 0;
    int n_pass = 0;

    typedef struct {
        logic [7:0]  data;
        logic [3:0]  len;
        logic        pen;
        logic        odd;
        logic        stop2;
        logic [15:0] baud;
        int          nbits;
        logic [15:0] bits;
    } vec_t;

    vec_t        vecs[10];
    logic [15:0] obs;
    int          dk, dc, wt, done_seen;

    uart_tx_engine #(.DATA_WIDTH(8), .BAUD_DIV_WIDTH(16), .FIFO_DEPTH(4)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .iBAUD_DIV   (iBAUD_DIV),
        .iDATA_LEN   (iDATA_LEN),
        .iPARITY_EN  (iPARITY_EN),
        .iODD_PARITY (iODD_PARITY),
        .iSTOP_BIT   (iSTOP_BIT),
        .iVALID      (iVALID),
        .iDATA       (iDATA),
        .oREADY      (oREADY),
        .oBUSY       (oBUSY),
        .oTX_DONE    (oTX_DONE),
        .oUART_TX    (oUART_TX)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic apply(input vec_t v);
        iDATA       = v.data;
        iDATA_LEN   = v.len;
        iPARITY_EN  = v.pen;
        iODD_PARITY = v.odd;
        iSTOP_BIT   = v.stop2;
        iBAUD_DIV   = v.baud;
    endtask

    // Call #1 after the edge that moved the engine out of IDLE; samples each line bit mid-period.
    task automatic watch_frame(input int p, input int n, output logic [15:0] o, output int done_k,
                               output int done_cnt);
        o = '0;
        done_k = -1;
        done_cnt = 0;
        for (int k = 1; k <= p * n; k++) begin
            @(posedge CLK);
            #1;
            if (oTX_DONE) begin
                done_cnt++;
                done_k = k;
            end
            if (k - 1 >= p / 2 && (k - 1 - p / 2) % p == 0) o[(k - 1 - p / 2) / p] = oUART_TX;
        end
    endtask

    task automatic wait_busy(output int waited);
        waited = 0;
        do begin
            @(posedge CLK);
            #1;
            waited++;
        end while (!oBUSY && waited < 200);
    endtask

    task automatic run_frame(input vec_t v, input string name);
        logic [15:0] o;
        int          k_done, n_done, w;
        int          p;
        p = int'(v.baud) + 1;
        @(negedge CLK);
        apply(v);
        iVALID = 1'b1;
        chk({name, " ready"}, 32'(oREADY), 1);
        @(posedge CLK);
        #1;
        iVALID = 1'b0;
        w = 1;
        if (!oBUSY) wait_busy(w);
        chk({name, " started"}, 32'(oBUSY), 1);
        iDATA       = ~v.data;
        iDATA_LEN   = 4'd5;
        iPARITY_EN  = ~v.pen;
        iODD_PARITY = ~v.odd;
        iSTOP_BIT   = ~v.stop2;
        iBAUD_DIV   = v.baud + 16'd2;
        watch_frame(p, v.nbits, o, k_done, n_done);
        chk({name, " bits"}, 32'(o), 32'(v.bits));
        chk({name, " done_at"}, k_done, p * v.nbits - 1);
        chk({name, " done_count"}, n_done, 1);
        chk({name, " idle busy/ready/line"}, {29'd0, oBUSY, oREADY, oUART_TX}, 3'b011);
    endtask

`ifdef UART_TX_FIFO_EN
    logic [7:0]  w5[6];
    logic [15:0] obs5;
    int          dk5, dc5, wt5, saw_full;
`endif

    initial begin
        vecs[0] = '{8'h55, 4'd8,  1'b0, 1'b0, 1'b0, 16'd3, 10, 16'h02AA};
        vecs[1] = '{8'h41, 4'd7,  1'b1, 1'b0, 1'b1, 16'd3, 11, 16'h0682};
        vecs[2] = '{8'h00, 4'd8,  1'b1, 1'b1, 1'b0, 16'd3, 11, 16'h0600};
        vecs[3] = '{8'hFF, 4'd8,  1'b1, 1'b1, 1'b0, 16'd3, 11, 16'h07FE};
        vecs[4] = '{8'hFE, 4'd8,  1'b1, 1'b0, 1'b0, 16'd3, 11, 16'h07FC};
        vecs[5] = '{8'hA5, 4'd0,  1'b0, 1'b0, 1'b0, 16'd3, 10, 16'h034A};
        vecs[6] = '{8'hFF, 4'd5,  1'b1, 1'b1, 1'b0, 16'd3,  8, 16'h00BE};
        vecs[7] = '{8'h3C, 4'd12, 1'b0, 1'b0, 1'b1, 16'd3, 11, 16'h0678};
        vecs[8] = '{8'h55, 4'd8,  1'b0, 1'b0, 1'b0, 16'd0, 10, 16'h02AA};
        vecs[9] = '{8'h41, 4'd7,  1'b1, 1'b0, 1'b1, 16'd1, 11, 16'h0682};

        repeat (3) @(posedge CLK);
        #1;
        chk("reset line", 32'(oUART_TX), 1);
        chk("reset busy", 32'(oBUSY), 0);
        chk("reset done", 32'(oTX_DONE), 0);
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        chk("ready after reset", 32'(oREADY), 1);

        for (int i = 0; i < 10; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

`ifndef UART_TX_FIFO_EN
        // Word held valid while busy; data changes must not leak into the frame in flight.
        @(negedge CLK);
        apply(vecs[0]);
        iVALID = 1'b1;
        @(posedge CLK);
        #1;
        iDATA = 8'hC3;
        chk("t4 ready low while busy", 32'(oREADY), 0);
        watch_frame(4, 10, obs, dk, dc);
        chk("t4 first bits", 32'(obs), 32'h02AA);
        chk("t4 first done_at", dk, 39);
        chk("t4 ready 1 clk after done", 32'(oREADY), 1);
        @(posedge CLK);
        #1;
        iVALID = 1'b0;
        chk("t4 second started", 32'(oBUSY), 1);
        watch_frame(4, 10, obs, dk, dc);
        chk("t4 second bits", 32'(obs), 32'h0386);
        chk("t4 second done_count", dc, 1);
`else
        w5 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        saw_full = 0;
        @(negedge CLK);
        apply(vecs[0]);
        fork
            begin : p_push
                int acc;
                for (int i = 0; i < 6; i++) begin
                    iDATA = w5[i];
                    iVALID = 1'b1;
                    acc = 0;
                    for (int t = 0; t < 400 && acc == 0; t++) begin
                        @(negedge CLK);
                        if (oREADY) acc = 1;
                        else saw_full = 1;
                        @(posedge CLK);
                        #1;
                    end
                    if (acc == 0) chk("t5 push timeout", 0, 1);
                end
                iVALID = 1'b0;
            end
            begin : p_watch
                for (int m = 0; m < 6; m++) begin
                    wait_busy(wt5);
                    chk("t5 started", 32'(oBUSY), 1);
                    if (m > 0) chk("t5 gap", wt5, 1);
                    watch_frame(4, 10, obs5, dk5, dc5);
                    chk("t5 word", 32'(obs5), {22'd0, 1'b1, w5[m], 1'b0});
                end
            end
        join
        chk("t5 ready dropped when full", saw_full, 1);
`endif

        // Reset in the middle of the data bits at one clock per bit.
        @(negedge CLK);
        apply('{8'h00, 4'd8, 1'b0, 1'b0, 1'b0, 16'd0, 10, 16'h0200});
        iVALID = 1'b1;
        @(posedge CLK);
        #1;
        iVALID = 1'b0;
        if (!oBUSY) wait_busy(wt);
        repeat (2) begin
            @(posedge CLK);
            #1;
        end
        chk("t6 line low in data", 32'(oUART_TX), 0);
        RST_N = 1'b0;
        #1;
        chk("t6 line high at reset", 32'(oUART_TX), 1);
        chk("t6 busy cleared", 32'(oBUSY), 0);
        done_seen = 0;
        repeat (3) begin
            @(posedge CLK);
            #1;
            if (oTX_DONE) done_seen = 1;
        end
        chk("t6 no done in reset", done_seen, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        run_frame(vecs[1], "t6 after reset");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
